// File: rtl/frame_pkg.sv
// Shared types and default parameters for the frame splitter slice.
package frame_pkg;

   localparam int DW_DEF       = 128;
   localparam int META_LEN_DEF = 2;
   localparam int CW_DEF       = 32;
   localparam int ERR_CNT_W    = 16;

   typedef enum logic [1:0] {
      S_DATA,
      S_META,
      S_CNT
   } state_t;

   // A configured length of zero still produces one data beat per frame.
   function automatic logic [31:0] beats_eff(input logic [31:0] n);
      return (n == 32'd0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/frame_splitter_if.sv
// Framed input stream plus the split payload and metadata streams.
interface frame_splitter_if import frame_pkg::*; #(
   parameter int DW = DW_DEF
) ();

   logic [DW-1:0] in_tdata;
   logic          in_tvalid;
   logic          in_tready;

   logic [DW-1:0] data_tdata;
   logic          data_tvalid;
   logic          data_tready;
   logic          data_tlast;

   logic [DW-1:0] meta_tdata;
   logic          meta_tvalid;
   logic          meta_tready;
   logic          meta_tlast;

   // Environment side: drives the framed stream and the sink readies.
   modport master (
      output in_tdata, in_tvalid, data_tready, meta_tready,
      input  in_tready, data_tdata, data_tvalid, data_tlast,
             meta_tdata, meta_tvalid, meta_tlast
   );

   // Splitter side.
   modport slave (
      input  in_tdata, in_tvalid, data_tready, meta_tready,
      output in_tready, data_tdata, data_tvalid, data_tlast,
             meta_tdata, meta_tvalid, meta_tlast
   );

endinterface

// File: rtl/seq_checker.sv
// Frame-counter continuity checker with a saturating discontinuity count.
module seq_checker import frame_pkg::*; #(
   parameter int CW = CW_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [CW-1:0]        cnt_in,
   input  logic                 cnt_strobe,
   output logic                 seq_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic          has_prev;
   logic [CW-1:0] prev_cnt;
   logic [CW-1:0] next_exp;

   // Wraps naturally: all-ones followed by zero is continuous.
   assign next_exp = prev_cnt + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         has_prev  <= 1'b0;
         prev_cnt  <= '0;
         seq_err   <= 1'b0;
         err_count <= '0;
      end else begin
         seq_err <= 1'b0;
         if (cnt_strobe) begin
            has_prev <= 1'b1;
            prev_cnt <= cnt_in;
            if (has_prev && (cnt_in != next_exp)) begin
               seq_err <= 1'b1;
               if (err_count != '1)
                  err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/frame_splitter.sv
// Splits a framed stream into payload and metadata streams and extracts the
// frame counter. Define FRAME_SPLITTER_SEQ_CHECK_EN to enable the continuity check.
module frame_splitter import frame_pkg::*; #(
   parameter int DW       = DW_DEF,
   parameter int META_LEN = META_LEN_DEF,
   parameter int CW       = CW_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          data_beats,
   frame_splitter_if.slave      bus,
   output logic [CW-1:0]        frame_cnt,
   output logic                 frame_cnt_valid,
   output logic                 seq_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t      state, state_nxt;
   logic [31:0] beat_cnt, beat_cnt_nxt;
   logic [31:0] beats_lat;
   logic        cnt_strobe;

   // Frame length is frozen at frame start so mid-frame changes wait a frame.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= S_DATA;
         beat_cnt  <= '0;
         beats_lat <= beats_eff(data_beats);
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
         if (cnt_strobe)
            beats_lat <= beats_eff(data_beats);
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt        = state;
      beat_cnt_nxt     = beat_cnt;
      cnt_strobe       = 1'b0;
      bus.in_tready    = 1'b0;
      bus.data_tdata   = '0;
      bus.data_tvalid  = 1'b0;
      bus.data_tlast   = 1'b0;
      bus.meta_tdata   = '0;
      bus.meta_tvalid  = 1'b0;
      bus.meta_tlast   = 1'b0;

      if (resetn) begin
         case (state)
            S_DATA: begin
               bus.data_tdata  = bus.in_tdata;
               bus.data_tvalid = bus.in_tvalid;
               bus.data_tlast  = (beat_cnt == beats_lat - 32'd1);
               bus.in_tready   = bus.data_tready;
               if (bus.in_tvalid && bus.data_tready) begin
                  if (bus.data_tlast) begin
                     beat_cnt_nxt = '0;
                     state_nxt    = S_META;
                  end else begin
                     beat_cnt_nxt = beat_cnt + 32'd1;
                  end
               end
            end
            S_META: begin
               bus.meta_tdata  = bus.in_tdata;
               bus.meta_tvalid = bus.in_tvalid;
               bus.meta_tlast  = (beat_cnt == 32'(META_LEN - 1));
               bus.in_tready   = bus.meta_tready;
               if (bus.in_tvalid && bus.meta_tready) begin
                  if (bus.meta_tlast) begin
                     beat_cnt_nxt = '0;
                     state_nxt    = S_CNT;
                  end else begin
                     beat_cnt_nxt = beat_cnt + 32'd1;
                  end
               end
            end
            S_CNT: begin
               bus.in_tready = 1'b1;
               if (bus.in_tvalid) begin
                  cnt_strobe = 1'b1;
                  state_nxt  = S_DATA;
               end
            end
            default: state_nxt = S_DATA;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_cnt       <= '0;
         frame_cnt_valid <= 1'b0;
      end else begin
         frame_cnt_valid <= cnt_strobe;
         if (cnt_strobe)
            frame_cnt <= bus.in_tdata[CW-1:0];
      end
   end

`ifdef FRAME_SPLITTER_SEQ_CHECK_EN
   seq_checker #(.CW(CW)) u_seq_checker (
      .clk        (clk),
      .resetn     (resetn),
      .cnt_in     (bus.in_tdata[CW-1:0]),
      .cnt_strobe (cnt_strobe),
      .seq_err    (seq_err),
      .err_count  (err_count)
   );
`else
   assign seq_err   = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: doc/frame_splitter.md
# frame_splitter

Receive-side stage that consumes the framed AXI-Stream produced by the header insertion stage. Each frame is a run of data beats, then a fixed number of metadata beats, then one frame-counter beat. This block splits the frame back into a data stream and a metadata stream, extracts the frame counter, and checks counter continuity. It sits directly downstream of the header adder, ahead of the sink/DMA logic.

## Interface
- DW, 128, data width of all streams
- META_LEN, 2, metadata beats per frame (≥1)
- CW, 32, frame-counter width taken from bits [CW-1:0] of the counter beat
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- data_beats  in  32  data beats per frame; sampled on entry to S_DATA; 0 treated as 1
- axis_in_tdata / axis_in_tvalid / axis_in_tready  in/in/out  DW/1/1  framed input stream
- axis_data_tdata / tvalid / tready / tlast  out/out/in/out  DW/1/1/1  payload stream
- axis_meta_tdata / tvalid / tready / tlast  out/out/in/out  DW/1/1/1  metadata stream
- frame_cnt  out  CW  last received frame counter
- frame_cnt_valid  out  1  one-cycle pulse, frame_cnt updated
- seq_err  out  1  one-cycle pulse, counter discontinuity
- err_count  out  16  saturating discontinuity count

## Operation
- FSM states: S_DATA, S_META, S_CNT. Reset state is S_DATA.
- Beat counter beat_cnt[31:0]. beats_lat latches max(data_beats,1) on reset exit and on every S_CNT→S_DATA transition.
- S_DATA routing:
  - axis_data_tvalid = axis_in_tvalid; axis_in_tready = axis_data_tready; tdata passes through.
  - axis_data_tlast = (beat_cnt == beats_lat-1).
  - On handshake, beat_cnt increments. On the last beat, beat_cnt clears and the FSM goes to S_META.
- S_META routing:
  - Same routing onto the meta stream; axis_meta_tlast = (beat_cnt == META_LEN-1).
  - On handshake of the last meta beat, the FSM goes to S_CNT.
- S_CNT:
  - axis_in_tready = 1.
  - On tvalid, latch tdata[CW-1:0] into frame_cnt, pulse frame_cnt_valid, run the sequence check, then go to S_DATA.
- Sequence check:
  - has_prev flag is cleared by reset.
  - When has_prev = 1 and the new counter ≠ frame_cnt+1 (mod 2^CW), pulse seq_err and increment err_count, saturating at 16'hFFFF.
  - The first counter beat after reset sets has_prev and never errors.
- Output valids not belonging to the current state are 0. Input beats are never dropped or duplicated.
- Reset mid-frame: the FSM returns to S_DATA, beat_cnt = 0, has_prev = 0. The partial frame is discarded. The upstream stage is reset by the same resetn.

## Timing
- Data and meta paths have zero latency (combinational route). tready propagates combinationally from the selected sink.
- frame_cnt, frame_cnt_valid, seq_err, err_count are registered and update the cycle after the counter-beat handshake.
- Reset values:
  - axis_in_tready = 0 while resetn = 0.
  - All tvalid/tlast = 0 and all tdata = 0.
  - frame_cnt = 0, frame_cnt_valid = 0, seq_err = 0, err_count = 0.
- data_beats changes mid-frame have no effect until the next frame.
- Wrap: frame_cnt all-ones followed by 0 is continuous.
- Back-to-back frames run at 1 beat/cycle with no idle cycle between frames.

## Configuration
- FRAME_SPLITTER_SEQ_CHECK_EN:
  - Defined: continuity check, seq_err and err_count as described.
  - Undefined: the checker is not instantiated, seq_err and err_count are tied to 0, and has_prev is absent. Routing and frame_cnt are unchanged.

## Structure
- Package frame_pkg:
  - State enum (S_DATA/S_META/S_CNT).
  - Default DW/CW/META_LEN constants.
  - ERR_CNT_W = 16.
- Sub-module seq_checker:
  - Inputs: clk, resetn, cnt_in, cnt_strobe.
  - Outputs: seq_err, err_count.
  - Owns has_prev and the saturating counter. Instantiated only under FRAME_SPLITTER_SEQ_CHECK_EN.

## Test plan
- data_beats=4, META_LEN=2, counter beats 5,6,7, sinks always ready:
  - 4 data beats per frame, tlast on the 4th; 2 meta beats, tlast on the 2nd.
  - frame_cnt_valid pulses with 5,6,7; seq_err never asserts.
- Counter sequence 10,11,13,14:
  - Exactly one seq_err pulse, on 13; err_count = 1.
- Counter 32'hFFFFFFFF then 0:
  - No seq_err. frame_cnt = 0 one cycle after the handshake.
- Random axis_data_tready/axis_meta_tready toggling at 50%:
  - Output beat order and content match the input exactly.
  - axis_in_tready mirrors the selected sink; the counter beat is accepted in one cycle.
- resetn pulsed low after 2 of 4 data beats:
  - All outputs 0 during reset.
  - Next frame starts in S_DATA with beat_cnt = 0.
  - The first counter beat after reset (e.g. 100) gives no seq_err.
- data_beats=0:
  - Each frame carries exactly 1 data beat, with tlast set.
